dtcu_frame_scheduler: RTL and testbench
=======================================

Name: dtcu_frame_scheduler

Overview:
- Sequences the display transmission control unit (DTCU) at the front end of the GPU display path.
- After reset it issues the display init transaction once, then periodic or on-demand frame transmissions.
- Owns double-buffer front/back selection: buffer swaps commit only between transactions.
- On NACK or a missing busy response it retries with backoff, then latches a fault.

Parameters:
REFRESH_CYCLES, 400000, clk cycles between automatic frame sends (4 ms at 100 MHz); >=2
MAX_RETRIES, 3, retries per transaction after the first attempt fails; >=0
BACKOFF_CYCLES, 1000, idle cycles between a failed attempt and its retry; >=1
START_TIMEOUT, 16, cycles allowed after a start pulse for dtcu_busy to rise; >=1
RW, $clog2(MAX_RETRIES+1), retry_count width (derived, not overridable)

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high
enable  in  1  level; allows automatic refresh timer
frame_req  in  1  1-cycle pulse; request one frame send
swap_req  in  1  1-cycle pulse; producer finished back buffer
clear_fault  in  1  1-cycle pulse; leave FAULT and re-init
dtcu_busy  in  1  DTCU busy level
dtcu_nack  in  1  DTCU NACK indication, any cycle during a transaction
init_display  out  1  1-cycle start pulse to DTCU
send_frame  out  1  1-cycle start pulse to DTCU
front_sel  out  1  buffer index DTCU reads (0/1)
swap_ack  out  1  1-cycle pulse when a swap commits
ready  out  1  init completed successfully
fault  out  1  sticky failure flag
retry_count  out  RW  retries consumed by the current transaction
frame_count  out  16  successful frames sent, wraps 0xFFFF->0

Behaviour:
- Reset (async): all outputs 0, state INIT_ISSUE, timer 0, pending flags 0, nack latch 0. First pulse follows on the first clk edge after reset falls.
- INIT_ISSUE: init_display=1 for 1 cycle; kind:=INIT; -> WAIT_START.
- FRAME_ISSUE: send_frame=1 for 1 cycle; kind:=FRAME; clear refresh/frame pending; -> WAIT_START.
- WAIT_START: count cycles; dtcu_busy=1 -> WAIT_DONE. START_TIMEOUT cycles elapse without busy -> failure.
- WAIT_DONE:
  - dtcu_nack=1 on any cycle from the start pulse onward sets the nack latch.
  - dtcu_busy=0 -> success if the latch is clear, else failure. Clear the latch.
- Success, INIT: ready:=1, retry_count:=0, -> IDLE.
- Success, FRAME: frame_count+1, retry_count:=0, -> IDLE.
- Failure:
  - retry_count<MAX_RETRIES: retry_count+1, -> BACKOFF.
  - Otherwise -> FAULT.
- BACKOFF: wait exactly BACKOFF_CYCLES cycles, then -> INIT_ISSUE or FRAME_ISSUE per kind (same transaction).
- FAULT:
  - fault=1; no pulses; retry_count holds; ready unchanged.
  - clear_fault -> fault:=0, ready:=0, retry_count:=0, pending flags cleared, -> INIT_ISSUE.
  - clear_fault in any other state is ignored.
- Refresh timer:
  - Increments each cycle while enable=1 and ready=1 (any state except FAULT).
  - At REFRESH_CYCLES-1: wraps to 0 and sets refresh_pending.
  - enable=0 holds the timer value.
- frame_req: sets frame_pending in any state except FAULT, even before ready. A frame is not sent until IDLE.
- Pending coalescing: at most one frame outstanding. Further requests or timer wraps while pending are absorbed.
- swap_req: sets swap_pending in any state except FAULT. A second swap_req while pending coalesces, giving one swap_ack.
- IDLE priority, evaluated each cycle:
  1. swap_pending: front_sel toggles, swap_ack=1, clear swap_pending, stay IDLE.
  2. Else (refresh_pending | frame_pending): -> FRAME_ISSUE next cycle.
- front_sel never changes outside IDLE, so it is stable for a whole transaction.
- Simultaneous events:
  - swap_req in the same IDLE cycle a frame is pending: the swap commits the following IDLE cycle, and the frame is issued first.
  - frame_req on the same cycle the FRAME_ISSUE pulse clears pending: the request is kept pending.
- dtcu_busy rising outside WAIT_START/WAIT_DONE is ignored.

Test Plan:
(All tests: REFRESH_CYCLES=100, MAX_RETRIES=2, BACKOFF_CYCLES=10, START_TIMEOUT=8. DTCU model raises busy 2 cycles after a pulse and holds it 20 cycles.)
1. Reset release, enable=0 -> one init_display pulse on the first edge; ready=1 after busy falls; no send_frame for 500 cycles; frame_count=0.
2. enable=1 after ready -> send_frame every 100 cycles (pulse spacing exactly 100); frame_count=5 after 5 frames; 3 frame_req pulses during one transfer -> exactly one extra frame.
3. swap_req during a frame transfer -> front_sel constant until busy falls, then toggles in the first IDLE cycle; swap_ack exactly 1 pulse; two swap_req pulses coalesce into one toggle.
4. Model asserts dtcu_nack on the first frame attempt only -> BACKOFF 10 cycles, one resend, retry_count=1 then 0; frame_count increments once.
5. Model never raises busy -> init_display pulses at t0, t0+19, t0+38 (8 timeout + 10 backoff + 1 issue); fault=1, ready=0; clear_fault -> fault=0, new init_display pulse.
6. reset asserted mid-WAIT_DONE -> all outputs 0 immediately, with no clock edge needed; after release, init sequence restarts with front_sel=0.

Source files
------------

// File: rtl/dtcu_frame_scheduler.sv
// Display front-end sequencer: issues DTCU init and frame sends, owns the
// front/back buffer select, retries failed transactions with backoff, latches faults.
module dtcu_frame_scheduler #(
  parameter int REFRESH_CYCLES = 400000,
  parameter int MAX_RETRIES    = 3,
  parameter int BACKOFF_CYCLES = 1000,
  parameter int START_TIMEOUT  = 16,
  localparam int RW = (MAX_RETRIES > 0) ? $clog2(MAX_RETRIES + 1) : 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          enable,
  input  logic          frame_req,
  input  logic          swap_req,
  input  logic          clear_fault,
  input  logic          dtcu_busy,
  input  logic          dtcu_nack,
  output logic          init_display,
  output logic          send_frame,
  output logic          front_sel,
  output logic          swap_ack,
  output logic          ready,
  output logic          fault,
  output logic [RW-1:0] retry_count,
  output logic [15:0]   frame_count
);

  localparam int CMAX = (START_TIMEOUT > BACKOFF_CYCLES) ?
                        START_TIMEOUT : BACKOFF_CYCLES;
  localparam int CW = $clog2(CMAX + 1);
  localparam int TW = $clog2(REFRESH_CYCLES);

  localparam logic [2:0] S_INIT_ISSUE  = 3'd0;
  localparam logic [2:0] S_FRAME_ISSUE = 3'd1;
  localparam logic [2:0] S_WAIT_START  = 3'd2;
  localparam logic [2:0] S_WAIT_DONE   = 3'd3;
  localparam logic [2:0] S_IDLE        = 3'd4;
  localparam logic [2:0] S_BACKOFF     = 3'd5;
  localparam logic [2:0] S_FAULT       = 3'd6;

  logic [2:0]    state;
  logic          kind;
  logic [CW-1:0] cnt;
  logic          nack_lat;
  logic [TW-1:0] timer;
  logic          refresh_pending;
  logic          frame_pending;
  logic          swap_pending;

  logic tick;
  logic wrap;
  logic nack_any;
  logic ok;
  logic fail;
  logic can_retry;

  always_comb begin
    tick      = enable && ready && (state != S_FAULT);
    wrap      = tick && (timer == TW'(REFRESH_CYCLES - 1));
    nack_any  = nack_lat || dtcu_nack;
    can_retry = int'(retry_count) < MAX_RETRIES;
    ok        = 1'b0;
    fail      = 1'b0;
    unique case (1'b1)
      (state == S_WAIT_START): begin
        fail = !dtcu_busy && (cnt == CW'(START_TIMEOUT - 1));
      end
      (state == S_WAIT_DONE): begin
        ok   = !dtcu_busy && !nack_any;
        fail = !dtcu_busy && nack_any;
      end
      default: ;
    endcase
  end

  // Request capture; a set on the same edge as the issue clear wins.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      timer           <= '0;
      refresh_pending <= 1'b0;
      frame_pending   <= 1'b0;
      swap_pending    <= 1'b0;
    end else if (state == S_FAULT) begin
      if (clear_fault) begin
        refresh_pending <= 1'b0;
        frame_pending   <= 1'b0;
        swap_pending    <= 1'b0;
      end
    end else begin
      if (tick) begin
        timer <= wrap ? '0 : timer + 1'b1;
      end
      if (wrap) begin
        refresh_pending <= 1'b1;
      end else if (state == S_FRAME_ISSUE) begin
        refresh_pending <= 1'b0;
      end
      if (frame_req) begin
        frame_pending <= 1'b1;
      end else if (state == S_FRAME_ISSUE) begin
        frame_pending <= 1'b0;
      end
      if (swap_req) begin
        swap_pending <= 1'b1;
      end else if (state == S_IDLE) begin
        swap_pending <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= S_INIT_ISSUE;
      kind         <= 1'b0;
      cnt          <= '0;
      nack_lat     <= 1'b0;
      init_display <= 1'b0;
      send_frame   <= 1'b0;
      front_sel    <= 1'b0;
      swap_ack     <= 1'b0;
      ready        <= 1'b0;
      fault        <= 1'b0;
      retry_count  <= '0;
      frame_count  <= '0;
    end else begin
      init_display <= 1'b0;
      send_frame   <= 1'b0;
      swap_ack     <= 1'b0;
      unique case (state)
        S_INIT_ISSUE: begin
          init_display <= 1'b1;
          kind         <= 1'b0;
          cnt          <= '0;
          nack_lat     <= 1'b0;
          state        <= S_WAIT_START;
        end
        S_FRAME_ISSUE: begin
          send_frame <= 1'b1;
          kind       <= 1'b1;
          cnt        <= '0;
          nack_lat   <= 1'b0;
          state      <= S_WAIT_START;
        end
        S_WAIT_START: begin
          if (dtcu_nack) begin
            nack_lat <= 1'b1;
          end
          if (dtcu_busy) begin
            state <= S_WAIT_DONE;
          end else if (!fail) begin
            cnt <= cnt + 1'b1;
          end
        end
        S_WAIT_DONE: begin
          if (dtcu_nack) begin
            nack_lat <= 1'b1;
          end
          if (!dtcu_busy) begin
            nack_lat <= 1'b0;
          end
          if (ok) begin
            retry_count <= '0;
            state       <= S_IDLE;
            if (kind) begin
              frame_count <= frame_count + 16'd1;
            end else begin
              ready <= 1'b1;
            end
          end
        end
        S_BACKOFF: begin
          if (cnt == CW'(BACKOFF_CYCLES - 1)) begin
            state <= kind ? S_FRAME_ISSUE : S_INIT_ISSUE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        // A pending swap always commits before the next frame is issued.
        S_IDLE: begin
          if (swap_pending) begin
            front_sel <= ~front_sel;
            swap_ack  <= 1'b1;
          end else if (refresh_pending || frame_pending) begin
            state <= S_FRAME_ISSUE;
          end
        end
        S_FAULT: begin
          if (clear_fault) begin
            fault       <= 1'b0;
            ready       <= 1'b0;
            retry_count <= '0;
            state       <= S_INIT_ISSUE;
          end
        end
        default: begin
          state <= S_INIT_ISSUE;
        end
      endcase
      if (fail) begin
        cnt <= '0;
        if (can_retry) begin
          retry_count <= retry_count + 1'b1;
          state       <= S_BACKOFF;
        end else begin
          fault <= 1'b1;
          state <= S_FAULT;
        end
      end
    end
  end

endmodule

// File: tb/tb_dtcu_frame_scheduler.sv
// Bench for dtcu_frame_scheduler: expected start/swap pulses queued per
// transaction, popped and compared by a monitor against a DTCU response model.
module tb_dtcu_frame_scheduler;

  localparam int RC = 100;
  localparam int MR = 2;
  localparam int BC = 10;
  localparam int ST = 8;
  localparam int BUSY_DLY = 2;
  localparam int BUSY_LEN = 20;
  localparam int TO_GAP = ST + BC + 1;
  localparam int NACK_GAP = BUSY_DLY + BUSY_LEN + BC + 1;

  localparam int W_READY = 0;
  localparam int W_BUSY  = 1;
  localparam int W_FAULT = 2;
  localparam int W_FC    = 3;
  localparam int W_QSIZE = 4;

  localparam int P_FRAME = 0;
  localparam int P_SWAP  = 1;
  localparam int P_CLEAR = 2;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic enable = 1'b0;
  logic frame_req = 1'b0;
  logic swap_req = 1'b0;
  logic clear_fault = 1'b0;
  logic dtcu_busy = 1'b0;
  logic dtcu_nack = 1'b0;
  logic init_display;
  logic send_frame;
  logic front_sel;
  logic swap_ack;
  logic ready;
  logic fault;
  logic [1:0] retry_count;
  logic [15:0] frame_count;

  typedef struct {
    int kind;
    int front;
    int retry;
    int gap;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int last[3];
  int m_front = 0;
  int no_busy = 0;
  int nack_left = 0;

  dtcu_frame_scheduler #(
    .REFRESH_CYCLES(RC),
    .MAX_RETRIES(MR),
    .BACKOFF_CYCLES(BC),
    .START_TIMEOUT(ST)
  ) dut (
    .clk(clk),
    .reset(reset),
    .enable(enable),
    .frame_req(frame_req),
    .swap_req(swap_req),
    .clear_fault(clear_fault),
    .dtcu_busy(dtcu_busy),
    .dtcu_nack(dtcu_nack),
    .init_display(init_display),
    .send_frame(send_frame),
    .front_sel(front_sel),
    .swap_ack(swap_ack),
    .ready(ready),
    .fault(fault),
    .retry_count(retry_count),
    .frame_count(frame_count)
  );

  initial forever #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: got no finish, want finish");
    $fatal(1);
  end

  task automatic check(input string nm, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d, want %0d", nm, act, req);
    end
  endtask

  task automatic expect_pulse(input int k, input int f, input int r,
                              input int g);
    exp_t e;
    e.kind = k;
    e.front = f;
    e.retry = r;
    e.gap = g;
    q.push_back(e);
  endtask

  task automatic pulse_in(input int which);
    @(negedge clk);
    frame_req = (which == P_FRAME);
    swap_req = (which == P_SWAP);
    clear_fault = (which == P_CLEAR);
    @(negedge clk);
    frame_req = 1'b0;
    swap_req = 1'b0;
    clear_fault = 1'b0;
  endtask

  function automatic int sig(input int w);
    case (w)
      W_READY: return int'(ready);
      W_BUSY:  return int'(dtcu_busy);
      W_FAULT: return int'(fault);
      W_FC:    return int'(frame_count);
      default: return q.size();
    endcase
  endfunction

  task automatic wait_cond(input string nm, input int w, input int lvl,
                           input int bound);
    int n;
    n = 0;
    while (sig(w) != lvl && n < bound) begin
      @(negedge clk);
      n++;
    end
    check(nm, sig(w), lvl);
  endtask

  // DTCU: busy rises 2 cycles after a start pulse and holds for 20 cycles.
  initial forever begin
    @(posedge clk);
    #1;
    if ((init_display || send_frame) && no_busy == 0) begin
      @(posedge clk);
      #1;
      dtcu_busy = 1'b1;
      for (int i = 0; i < BUSY_LEN; i++) begin
        dtcu_nack = (i == 5) && (nack_left > 0);
        @(posedge clk);
        #1;
      end
      dtcu_nack = 1'b0;
      dtcu_busy = 1'b0;
      if (nack_left > 0) nack_left--;
    end
  end

  initial begin
    int k;
    exp_t e;
    forever begin
      @(negedge clk);
      if (!reset && (init_display || send_frame || swap_ack)) begin
        k = init_display ? 0 : (send_frame ? 1 : 2);
        if (q.size() == 0) begin
          check("unexpected_pulse", k, -1);
        end else begin
          e = q.pop_front();
          check("pulse_kind", k, e.kind);
          check("pulse_front_sel", int'(front_sel), e.front);
          if (k != 2) check("pulse_retry", int'(retry_count), e.retry);
          if (e.gap > 0) check("pulse_gap", cyc - last[k], e.gap);
        end
        last[k] = cyc;
      end
    end
  end

  initial begin
    int fc;
    int n;
    int nb;
    int bad;
    int fs0;

    repeat (3) @(negedge clk);
    check("rst_init_display", int'(init_display), 0);
    check("rst_send_frame", int'(send_frame), 0);
    check("rst_ready", int'(ready), 0);
    check("rst_fault", int'(fault), 0);
    check("rst_frame_count", int'(frame_count), 0);

    expect_pulse(0, 0, 0, 0);
    reset = 1'b0;
    @(posedge clk);
    #1;
    check("first_edge_init", int'(init_display), 1);
    wait_cond("init_ready", W_READY, 1, 100);
    repeat (500) @(negedge clk);
    check("no_frame_enable0", int'(frame_count), 0);
    check("idle_q_empty", q.size(), 0);

    @(negedge clk);
    expect_pulse(1, m_front, 0, 0);
    for (int i = 0; i < 4; i++) expect_pulse(1, m_front, 0, RC);
    enable = 1'b1;
    wait_cond("refresh_5", W_FC, 5, 700);
    enable = 1'b0;
    check("refresh_q_empty", q.size(), 0);

    expect_pulse(1, m_front, 0, 0);
    expect_pulse(1, m_front, 0, 0);
    pulse_in(P_FRAME);
    wait_cond("req_busy", W_BUSY, 1, 20);
    for (int i = 0; i < 3; i++) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      pulse_in(P_FRAME);
    end
    wait_cond("extra_frame", W_FC, 7, 200);
    repeat (150) @(negedge clk);
    check("coalesced_count", int'(frame_count), 7);
    check("extra_q_empty", q.size(), 0);

    expect_pulse(1, m_front, 0, 0);
    m_front = 1 - m_front;
    expect_pulse(2, m_front, 0, 0);
    pulse_in(P_FRAME);
    wait_cond("swap_busy", W_BUSY, 1, 20);
    fs0 = int'(front_sel);
    nb = $urandom_range(1, 2);
    for (int i = 0; i < nb; i++) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      pulse_in(P_SWAP);
    end
    bad = 0;
    n = 0;
    while (dtcu_busy && n < 40) begin
      if (int'(front_sel) != fs0) bad++;
      @(negedge clk);
      n++;
    end
    check("front_stable", bad, 0);
    @(negedge clk);
    @(negedge clk);
    check("swap_first_idle", int'(swap_ack), 1);
    check("front_toggled", int'(front_sel), m_front);
    repeat (20) @(negedge clk);
    check("swap_q_empty", q.size(), 0);

    for (int t = 0; t < 3; t++) begin
      n = (t == 0) ? 1 : $urandom_range(0, MR);
      fc = int'(frame_count);
      for (int a = 0; a <= n; a++) begin
        expect_pulse(1, m_front, a, (a == 0) ? 0 : NACK_GAP);
      end
      nack_left = n;
      pulse_in(P_FRAME);
      wait_cond("nack_frame_done", W_FC, fc + 1, 300);
      check("nack_retry_cleared", int'(retry_count), 0);
      repeat (30) @(negedge clk);
      check("nack_single_count", int'(frame_count), fc + 1);
      check("nack_q_empty", q.size(), 0);
    end

    @(negedge clk);
    no_busy = 1;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    m_front = 0;
    expect_pulse(0, 0, 0, 0);
    expect_pulse(0, 0, 1, TO_GAP);
    expect_pulse(0, 0, 2, TO_GAP);
    reset = 1'b0;
    wait_cond("fault_set", W_FAULT, 1, 200);
    check("fault_ready", int'(ready), 0);
    check("fault_retry", int'(retry_count), MR);
    pulse_in(P_FRAME);
    pulse_in(P_SWAP);
    repeat (60) @(negedge clk);
    check("fault_q_empty", q.size(), 0);
    check("fault_sticky", int'(fault), 1);
    no_busy = 0;
    expect_pulse(0, 0, 0, 0);
    pulse_in(P_CLEAR);
    check("fault_cleared", int'(fault), 0);
    wait_cond("reinit_ready", W_READY, 1, 100);
    repeat (100) @(negedge clk);
    check("no_frame_after_clear", int'(frame_count), 0);
    check("clear_q_empty", q.size(), 0);

    m_front = 1;
    expect_pulse(2, m_front, 0, 0);
    pulse_in(P_SWAP);
    repeat (5) @(negedge clk);
    check("pre_reset_front", int'(front_sel), 1);
    expect_pulse(1, m_front, 0, 0);
    pulse_in(P_FRAME);
    wait_cond("r6_busy", W_BUSY, 1, 20);
    repeat (4) @(negedge clk);
    reset = 1'b1;
    #1;
    check("r6_front_sel", int'(front_sel), 0);
    check("r6_ready", int'(ready), 0);
    check("r6_fault", int'(fault), 0);
    check("r6_frame_count", int'(frame_count), 0);
    check("r6_retry", int'(retry_count), 0);
    check("r6_pulses", int'(init_display) + int'(send_frame) + int'(swap_ack), 0);
    wait_cond("r6_busy_low", W_BUSY, 0, 40);
    m_front = 0;
    expect_pulse(0, 0, 0, 0);
    @(negedge clk);
    reset = 1'b0;
    wait_cond("r6_reinit_ready", W_READY, 1, 100);
    check("r6_front_after", int'(front_sel), 0);

    wait_cond("final_drain", W_QSIZE, 0, 50);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
